// File: rtl/rh_gpv_change_capture.sv
// rh_gpv_change_capture: turns masked changes on vector_in into timestamped events buffered in a valid/ready FIFO
//   clock, reset (sync, active-low), enable
//   vector_in, mask          : sampled vector and per-bit change-detect mask
//   evt_valid/evt_ready      : head-entry handshake
//   evt_vector/delta/lost    : head entry (full vector, cycles since last event, preceding-drop flag)
//   level, drop_count        : FIFO occupancy and saturating dropped-event count
module rh_gpv_change_capture #(
  parameter int VECTOR_WIDTH = 32,
  parameter int TS_WIDTH     = 16,
  parameter int DEPTH        = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [VECTOR_WIDTH-1:0]   vector_in,
  input  logic [VECTOR_WIDTH-1:0]   mask,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [VECTOR_WIDTH-1:0]   evt_vector,
  output logic [TS_WIDTH-1:0]       evt_delta,
  output logic                      evt_lost,
  output logic [$clog2(DEPTH):0]    level,
  output logic [7:0]                drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = VECTOR_WIDTH + TS_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, BASELINE, ARMED} state_t;
  state_t state;
  logic [VECTOR_WIDTH-1:0] prev;
  logic base_ok;
  logic [TS_WIDTH-1:0] cnt;
  logic lost_pend;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [EW-1:0] entry;
  logic [LW-1:0] level_next;
  logic chg, pop, full, push, drop, load_new, load_next;
  always_comb begin
    state = !enable ? IDLE : base_ok ? ARMED : BASELINE;
    chg = (state == ARMED) && |((vector_in ^ prev) & mask);
    pop = evt_valid && evt_ready;
    full = level == LW'(DEPTH);
    push = chg && (!full || pop);
    drop = chg && full && !pop;
    entry = {vector_in, cnt, lost_pend};
    rd_next = rd_ptr + AW'(1);
    level_next = level + LW'(push) - LW'(pop);
    // the head registers take the new entry when it becomes the head, else the next stored one
    load_new = push && (level == '0 || (level == LW'(1) && pop));
    load_next = pop && level > LW'(1);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev <= '0;
      base_ok <= 1'b0;
      cnt <= '0;
      lost_pend <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      evt_valid <= 1'b0;
      evt_vector <= '0;
      evt_delta <= '0;
      evt_lost <= 1'b0;
      drop_count <= '0;
    end else begin
      base_ok <= enable;
      if (state != IDLE) prev <= vector_in;
      if (state == BASELINE || chg) cnt <= TS_WIDTH'(1);
      else if (state == ARMED && !(&cnt)) cnt <= cnt + TS_WIDTH'(1);
      if (push) lost_pend <= 1'b0;
      else if (drop) lost_pend <= 1'b1;
      if (drop && !(&drop_count)) drop_count <= drop_count + 8'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_next;
      level <= level_next;
      evt_valid <= level_next != '0;
      if (load_new) {evt_vector, evt_delta, evt_lost} <= entry;
      else if (load_next) {evt_vector, evt_delta, evt_lost} <= mem[rd_next];
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry;
  end
endmodule

// File: tb/tb_rh_gpv_change_capture.sv
// tb_rh_gpv_change_capture: directed self-checking bench for rh_gpv_change_capture
module tb_rh_gpv_change_capture;
  logic clock = 1'b0;
  logic reset, enable, evt_valid, evt_ready, evt_lost;
  logic [31:0] vector_in, mask, evt_vector;
  logic [3:0] evt_delta;
  logic [3:0] level;
  logic [7:0] drop_count;
  int n_chk = 0;
  int n_fail = 0;

  rh_gpv_change_capture #(.VECTOR_WIDTH(32), .TS_WIDTH(4), .DEPTH(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .vector_in(vector_in), .mask(mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_vector(evt_vector),
    .evt_delta(evt_delta), .evt_lost(evt_lost), .level(level), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; vector_in = 32'h0; mask = 32'hFFFF_FFFF; evt_ready = 1'b0;
    tick(2);
    check("rst_valid", evt_valid, 0);
    check("rst_vector", evt_vector, 0);
    check("rst_delta", evt_delta, 0);
    check("rst_lost", evt_lost, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_count, 0);

    reset = 1'b1; enable = 1'b1; vector_in = 32'h5;
    tick(10);
    check("base_valid", evt_valid, 0);
    check("base_level", level, 0);
    check("base_drop", drop_count, 0);

    enable = 1'b0; tick();
    vector_in = 32'h0; enable = 1'b1; tick();
    tick(2);
    vector_in = 32'h1; tick();
    check("single_valid", evt_valid, 1);
    check("single_vector", evt_vector, 32'h1);
    check("single_delta", evt_delta, 3);
    check("single_lost", evt_lost, 0);
    check("single_level", level, 1);
    tick();
    check("stall_valid", evt_valid, 1);
    check("stall_vector", evt_vector, 32'h1);
    check("stall_delta", evt_delta, 3);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("pop_valid", evt_valid, 0);
    check("pop_level", level, 0);
    check("pop_hold", evt_vector, 32'h1);
    tick();
    check("ready_idle_level", level, 0);

    mask = 32'hF0; vector_in = 32'h0; tick();
    check("mask_bit0", evt_valid, 0);
    vector_in = 32'h11; tick();
    check("mask_bit4_valid", evt_valid, 1);
    check("mask_bit4_vector", evt_vector, 32'h11);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("mask_pop_level", level, 0);

    mask = 32'hFFFF_FFFF;
    for (int i = 0; i < 11; i++) begin
      vector_in = 32'h100 + i;
      tick();
    end
    check("ovf_level", level, 8);
    check("ovf_drop", drop_count, 3);
    check("ovf_head", evt_vector, 32'h100);
    check("ovf_head_lost", evt_lost, 0);
    evt_ready = 1'b1; vector_in = 32'h200; tick();
    check("ovf_pp_level", level, 8);
    check("ovf_pp_drop", drop_count, 3);
    check("ovf_e2_vector", evt_vector, 32'h101);
    check("ovf_e2_delta", evt_delta, 1);
    check("ovf_e2_lost", evt_lost, 0);
    tick(7);
    check("ovf_e9_level", level, 1);
    check("ovf_e9_vector", evt_vector, 32'h200);
    check("ovf_e9_lost", evt_lost, 1);
    check("ovf_e9_delta", evt_delta, 1);
    tick();
    evt_ready = 1'b0;
    check("ovf_drained", level, 0);

    for (int i = 0; i < 8; i++) begin
      vector_in = 32'h300 + i;
      tick();
    end
    check("full_level", level, 8);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vector_in = 32'h400 + i;
      tick();
      check("fullpp_level", level, 8);
    end
    check("fullpp_drop", drop_count, 3);
    check("fullpp_head", evt_vector, 32'h305);
    tick(8);
    evt_ready = 1'b0;
    check("fullpp_drained", level, 0);
    check("fullpp_valid", evt_valid, 0);
    check("fullpp_hold", evt_vector, 32'h404);

    tick(40);
    vector_in = 32'h500; tick();
    check("sat_valid", evt_valid, 1);
    check("sat_delta", evt_delta, 15);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    enable = 1'b0; tick();
    vector_in = 32'h600; tick();
    enable = 1'b1; tick();
    check("gap_valid", evt_valid, 0);
    check("gap_level", level, 0);
    vector_in = 32'h601; tick();
    check("rearm_valid", evt_valid, 1);
    check("rearm_delta", evt_delta, 1);
    check("rearm_drop", drop_count, 3);

    vector_in = 32'h602; tick();
    check("mid_level", level, 2);
    reset = 1'b0; tick(); reset = 1'b1;
    check("midrst_level", level, 0);
    check("midrst_valid", evt_valid, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_vector", evt_vector, 0);
    vector_in = 32'h700; tick();
    check("midrst_base", evt_valid, 0);
    vector_in = 32'h701; tick();
    check("midrst_evt_delta", evt_delta, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rh_gpv_change_capture.md
# rh_gpv_change_capture

- Receive-side companion to the GPV vector interface: watches the DUT-driven `vector_in` bus and turns every masked change into a timestamped event.
- Events are buffered in a small FIFO and drained by a valid/ready consumer, typically the GPV monitor or a scoreboard shim.
- A sustained burst of toggles is therefore never lost silently: either it is queued, or the loss is counted and flagged.

## Interface
Parameters:
- `VECTOR_WIDTH`, 32: width of the sampled vector.
- `TS_WIDTH`, 16: width of the inter-event cycle delta.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `enable`  in  1: capture enable.
- `vector_in`  in  VECTOR_WIDTH: vector driven by the DUT.
- `mask`  in  VECTOR_WIDTH: 1 = bit participates in change detection.
- `evt_valid`  out  1: head entry available.
- `evt_ready`  in  1: consumer accepts head entry.
- `evt_vector`  out  VECTOR_WIDTH: full (unmasked) sampled vector at the event.
- `evt_delta`  out  TS_WIDTH: cycles since the previous detected event or baseline; saturating.
- `evt_lost`  out  1: one or more events were dropped immediately before this one.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_count`  out  8: total dropped events; saturates at 255.

## Operation
- Internal state:
  - `prev`: last sampled vector.
  - `base_ok`: baseline taken.
  - `cnt`: delta counter, TS_WIDTH bits.
  - `lost_pend`: a drop is pending report.
  - FIFO storage with read/write pointers and occupancy.
- Capture states:
  - IDLE (`enable`=0): no events; `base_ok`=0.
  - BASELINE: first enabled cycle. Loads `prev` from `vector_in`, sets `cnt`=1 and `base_ok`=1, generates no event.
  - ARMED: every enabled cycle registers `prev` from `vector_in`.
- Transitions:
  - `enable` deassert from any state → IDLE. FIFO contents, `drop_count` and `lost_pend` are retained.
  - Re-enable → BASELINE.
- Change detect (ARMED only):
  - `chg = |((vector_in ^ prev) & mask)`.
  - `mask` is applied combinationally, so a mask update takes effect the same cycle.
- On `chg`:
  - Candidate entry = {`vector_in`, `cnt`, `lost_pend`}.
  - `cnt` reloads to 1.
- With no `chg` in ARMED, `cnt` increments, saturating at 2^TS_WIDTH-1.
- Push, when `chg` and the FIFO is not full after this cycle's pop:
  - Entry is written.
  - `lost_pend` clears.
- Drop, when `chg` and the FIFO is full with no pop this cycle:
  - Entry is discarded.
  - `drop_count` increments (saturating).
  - `lost_pend` sets.
  - `cnt` still reloads to 1.
- Pop: `evt_valid && evt_ready`. The head advances; `evt_*` show the next entry or hold their values when the FIFO empties.
- `evt_ready` while `evt_valid`=0 has no effect.
- Simultaneous push and pop:
  - When full: both are accepted; `level` is unchanged.
  - When empty: the push lands and `evt_valid` rises next cycle (no bypass).
- Pointers wrap modulo DEPTH. `level` is in the range 0..DEPTH.

## Timing
- Reset, `reset`=0 at a rising edge:
  - Outputs: `evt_valid`=0, `evt_vector`=0, `evt_delta`=0, `evt_lost`=0, `level`=0, `drop_count`=0.
  - Internal: `base_ok`=0, `prev`=0, `cnt`=0, `lost_pend`=0.
  - Reset mid-burst discards all FIFO contents; the first enabled cycle after release is BASELINE.
- Event latency: a change present on `vector_in` in cycle k is written at the end of cycle k. `evt_valid` and the entry outputs are valid from cycle k+1.
- Delta numbering:
  - A change in the cycle directly after BASELINE reports `evt_delta`=1.
  - Back-to-back changes each report 1.
- Handshake:
  - `evt_*` are stable while `evt_valid`=1 and `evt_ready`=0.
  - Throughput is one pop per cycle.
- All outputs are registered; there is no combinational path from `evt_ready` or `vector_in` to any output.

## Test plan
- Reset and baseline: reset, `enable`=1, `mask`=all-ones, `vector_in`=0x5 held 10 cycles → no `evt_valid`, `level`=0, `drop_count`=0.
- Single change: baseline 0x0; 3 cycles later drive 0x1, `evt_ready`=0 → next cycle `evt_valid`=1, `evt_vector`=0x1, `evt_delta`=3, `evt_lost`=0, `level`=1; pulse `evt_ready` → `evt_valid`=0.
- Mask: `mask`=0xF0; toggle bit 0 → no event; toggle bit 4 with `vector_in`=0x11 → event with `evt_vector`=0x11.
- Overflow (DEPTH=8): `evt_ready`=0, toggle every cycle for 11 cycles → `level`=8, `drop_count`=3. Then drain, toggle again and drain → ninth popped event has `evt_lost`=1 and `evt_delta`=1.
- Full push+pop: keep the FIFO full, assert `evt_ready`=1 while toggling every cycle → `level` stays 8 and `drop_count` does not change.
- Saturation and enable gap: TS_WIDTH=4, no change for 40 cycles, then change → `evt_delta`=15. Drop `enable` for 2 cycles, change `vector_in`, re-enable → no event from the change made while disabled.
